// File: rtl/chu_video_slot_responder.sv
// chu_video_slot_responder
// Slot-bus responder for a video controller: ctrl/key/status registers plus a
// posted-write FIFO into slot-local video memory. The FIFO is drained into
// memory only while blank is high.
// Optional macro VIDEO_SLOT_RDBACK_EN: when defined, register readback with
// 1-cycle latency is built; otherwise slot_rd_data is tied to 0.
module chu_video_slot_responder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        slot_cs,
    input  logic        slot_mem_wr,
    input  logic [13:0] slot_reg_addr,
    input  logic [31:0] slot_wr_data,
    output logic [31:0] slot_rd_data,
    input  logic        blank,
    output logic        mem_we,
    output logic [12:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [31:0] ctrl_reg,
    output logic [31:0] key_reg,
    output logic        ovf
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t         state, state_next;
    logic [44:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_next;
    logic           empty, full;
    logic           wr_req, push, reg_wr, accept, drop, pop;
    logic [44:0]    head;

    // Address bits [12:2] are don't-care for register decode
    logic unused_addr;
    assign unused_addr = ^slot_reg_addr[12:2];

    assign wr_req = slot_cs & slot_mem_wr;
    assign push   = wr_req & slot_reg_addr[13];
    assign reg_wr = wr_req & ~slot_reg_addr[13];
    assign empty  = (count == '0);
    assign full   = (count == CW'(FIFO_DEPTH));
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;
    assign head   = fifo_mem[rd_ptr];

    // Drain FSM: the entry cycle already pops so a drain has no bubble
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (blank && !empty) begin
                    pop        = 1'b1;
                    state_next = (count_next == '0) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (blank && !empty) pop = 1'b1;
                if (!blank || count_next == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // FSM state, pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are meaningless while count says empty
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= {slot_reg_addr[12:0], slot_wr_data};
    end

    // Memory write port: strobe follows the pop, address/data hold otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_we <= pop;
            if (pop) {mem_addr, mem_wr_data} <= head;
        end
    end

    // Control/key registers and sticky overflow (set beats clear)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_reg <= '0;
            key_reg  <= '0;
            ovf      <= 1'b0;
        end else begin
            if (reg_wr && slot_reg_addr[1:0] == 2'd0) ctrl_reg <= slot_wr_data;
            if (reg_wr && slot_reg_addr[1:0] == 2'd1) key_reg  <= slot_wr_data;
            if (drop)
                ovf <= 1'b1;
            else if (reg_wr && slot_reg_addr[1:0] == 2'd2 && slot_wr_data[0])
                ovf <= 1'b0;
        end
    end

`ifdef VIDEO_SLOT_RDBACK_EN
    logic        rd_req;
    logic [4:0]  count5;
    logic [31:0] rd_mux;

    assign rd_req = slot_cs & ~slot_mem_wr;
    assign count5 = 5'(count);

    // Read mux; the memory window and reserved slot read as zero
    always_comb begin
        rd_mux = '0;
        if (!slot_reg_addr[13]) begin
            case (slot_reg_addr[1:0])
                2'd0:    rd_mux = ctrl_reg;
                2'd1:    rd_mux = key_reg;
                2'd2:    rd_mux = {23'd0, count5, 1'b0, full, empty, ovf};
                default: rd_mux = '0;
            endcase
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    slot_rd_data <= '0;
        else if (rd_req) slot_rd_data <= rd_mux;
    end
`else
    assign slot_rd_data = '0;
`endif

endmodule
